// File: rtl/imm_encoder.sv
// ============================================================================
// Module  : imm_encoder
// Brief   : Splits a 32-bit constant or branch offset into 16-bit imm + EOp
//           beats the immediate extender rebuilds; optional IMM_ENC_SELFCHECK_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module imm_encoder #(
  parameter bit PREFER_ZEXT = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_val,
  input  logic        in_br,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic [1:0]  out_eop,
  output logic        out_last,
  output logic        out_err
`ifdef IMM_ENC_SELFCHECK_EN
  ,
  output logic        chk_err
`endif
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_beat1 = 2'd1;
  localparam logic [1:0] c_st_beat2 = 2'd2;

  localparam logic [1:0] c_eop_sext = 2'b00;
  localparam logic [1:0] c_eop_zext = 2'b01;
  localparam logic [1:0] c_eop_lui  = 2'b10;
  localparam logic [1:0] c_eop_br   = 2'b11;

  logic [1:0]  r_state, w_state_nxt;
  logic        r_rdy_en;
  logic [15:0] r_imm, r_lo;
  logic [1:0]  r_eop;
  logic        r_last, r_err;

  logic        w_accept, w_hs;
  logic        w_sext_ok, w_br_ok;
  logic [15:0] w_c_imm;
  logic [1:0]  w_c_eop;
  logic        w_c_two, w_c_err;

  assign w_hs     = out_valid & out_ready;
  assign in_ready = r_rdy_en & ((r_state == c_st_idle) | (w_hs & out_last));
  assign w_accept = in_valid & in_ready;

  assign w_sext_ok = (&in_val[31:15]) | ~(|in_val[31:15]);
  assign w_br_ok   = (in_val[1:0] == 2'b00) & ((&in_val[31:17]) | ~(|in_val[31:17]));

  // Request classification; first matching encoding wins.
  always_comb begin
    w_c_imm = in_val[15:0];
    w_c_eop = c_eop_sext;
    w_c_two = 1'b0;
    w_c_err = 1'b0;
    if (in_br) begin
      w_c_eop = c_eop_br;
      if (w_br_ok) begin
        w_c_imm = in_val[17:2];
      end else begin
        w_c_imm = 16'h0000;
        w_c_err = 1'b1;
      end
    end else if (w_sext_ok && ((in_val > 32'h0000_7FFF) || !PREFER_ZEXT)) begin
      w_c_eop = c_eop_sext;
    end else if (in_val[31:16] == 16'h0000) begin
      w_c_eop = c_eop_zext;
    end else if (in_val[15:0] == 16'h0000) begin
      w_c_imm = in_val[31:16];
      w_c_eop = c_eop_lui;
    end else begin
      w_c_imm = in_val[31:16];
      w_c_eop = c_eop_lui;
      w_c_two = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= c_st_idle;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_accept) w_state_nxt = c_st_beat1;
      c_st_beat1: if (out_ready) begin
                    if (!r_last)       w_state_nxt = c_st_beat2;
                    else if (w_accept) w_state_nxt = c_st_beat1;
                    else               w_state_nxt = c_st_idle;
                  end
      c_st_beat2: if (out_ready) w_state_nxt = w_accept ? c_st_beat1 : c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Beat contents only change on accept, so outputs hold under back-pressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_imm  <= 16'h0000;
      r_lo   <= 16'h0000;
      r_eop  <= 2'b00;
      r_last <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_imm  <= w_c_imm;
      r_lo   <= in_val[15:0];
      r_eop  <= w_c_eop;
      r_last <= ~w_c_two;
      r_err  <= w_c_err;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_imm   = 16'h0000;
    out_eop   = 2'b00;
    out_last  = 1'b0;
    out_err   = 1'b0;
    case (r_state)
      c_st_beat1: begin
        out_valid = 1'b1;
        out_imm   = r_imm;
        out_eop   = r_eop;
        out_last  = r_last;
        out_err   = r_err;
      end
      c_st_beat2: begin
        out_valid = 1'b1;
        out_imm   = r_lo;
        out_eop   = c_eop_zext;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef IMM_ENC_SELFCHECK_EN
  function automatic logic [31:0] f_extend(input logic [15:0] imm, input logic [1:0] eop);
    case (eop)
      c_eop_sext: f_extend = {{16{imm[15]}}, imm};
      c_eop_zext: f_extend = {16'h0000, imm};
      c_eop_lui:  f_extend = {imm, 16'h0000};
      default:    f_extend = {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  logic [31:0] r_val, r_acc, w_rebuilt;

  // lui result of the first beat is OR'd with the ori result of the second.
  assign w_rebuilt = ((r_state == c_st_beat2) ? r_acc : 32'h0000_0000) | f_extend(out_imm, out_eop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_val   <= 32'h0000_0000;
      r_acc   <= 32'h0000_0000;
      chk_err <= 1'b0;
    end else begin
      chk_err <= 1'b0;
      if (w_accept) r_val <= in_val;
      if (w_hs) begin
        if (!out_last) r_acc   <= f_extend(out_imm, out_eop);
        else           chk_err <= !out_err && (w_rebuilt != r_val);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
// Module  : tb_imm_encoder
// Brief   : Directed-vector bench for imm_encoder with hand-computed beats
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imm_encoder;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_val;
  logic        in_br;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_eop;
  logic        out_last;
  logic        out_err;
`ifdef IMM_ENC_SELFCHECK_EN
  logic        chk_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  imm_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .in_br     (in_br),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_eop   (out_eop),
    .out_last  (out_last),
    .out_err   (out_err)
`ifdef IMM_ENC_SELFCHECK_EN
    ,
    .chk_err   (chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] imm, input logic [1:0] eop,
                          input logic last, input logic err);
    check_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, ".imm"},   {16'd0, out_imm},   {16'd0, imm});
    check_eq({tag, ".eop"},   {30'd0, out_eop},   {30'd0, eop});
    check_eq({tag, ".last"},  {31'd0, out_last},  {31'd0, last});
    check_eq({tag, ".err"},   {31'd0, out_err},   {31'd0, err});
  endtask

  task automatic chk_idle(input string tag);
    check_eq({tag, ".idle"}, {31'd0, out_valid}, 32'd0);
`ifdef IMM_ENC_SELFCHECK_EN
    check_eq({tag, ".chk_err"}, {31'd0, chk_err}, 32'd0);
`endif
  endtask

  // Entered and left at posedge+1 with out_ready=1.
  task automatic single(input string tag, input logic [31:0] val, input logic br,
                        input logic [15:0] imm, input logic [1:0] eop, input logic err);
    in_valid = 1'b1; in_val = val; in_br = br;
    check_eq({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_beat(tag, imm, eop, 1'b1, err);
    @(posedge clk); #1;
    chk_idle(tag);
  endtask

  task automatic pair(input string tag, input logic [31:0] val, input logic [15:0] hi,
                      input logic [15:0] lo, input int hold);
    out_ready = (hold == 0);
    in_valid = 1'b1; in_val = val; in_br = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_beat({tag, ".b1"}, hi, 2'b10, 1'b0, 1'b0);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      chk_beat({tag, ".hold"}, hi, 2'b10, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_beat({tag, ".b2"}, lo, 2'b01, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_idle(tag);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_val = 32'h0; in_br = 1'b0; out_ready = 1'b1;
    #12;
    check_eq("rst.valid",    {31'd0, out_valid}, 32'd0);
    check_eq("rst.imm",      {16'd0, out_imm},   32'd0);
    check_eq("rst.eop",      {30'd0, out_eop},   32'd0);
    check_eq("rst.last",     {31'd0, out_last},  32'd0);
    check_eq("rst.err",      {31'd0, out_err},   32'd0);
    check_eq("rst.in_ready", {31'd0, in_ready},  32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

    single("sext5",    32'h0000_0005, 1'b0, 16'h0005, 2'b00, 1'b0);
    single("sext7fff", 32'h0000_7FFF, 1'b0, 16'h7FFF, 2'b00, 1'b0);
    single("zero",     32'h0000_0000, 1'b0, 16'h0000, 2'b00, 1'b0);
    single("zext8000", 32'h0000_8000, 1'b0, 16'h8000, 2'b01, 1'b0);
    single("sext_neg", 32'hFFFF_8000, 1'b0, 16'h8000, 2'b00, 1'b0);
    single("minus1",   32'hFFFF_FFFF, 1'b0, 16'hFFFF, 2'b00, 1'b0);
    single("lui1234",  32'h1234_0000, 1'b0, 16'h1234, 2'b10, 1'b0);
    single("luiffff",  32'hFFFF_0000, 1'b0, 16'hFFFF, 2'b10, 1'b0);

    single("br_m4",    32'hFFFF_FFFC, 1'b1, 16'hFFFF, 2'b11, 1'b0);
    single("br_max",   32'h0001_FFFC, 1'b1, 16'h7FFF, 2'b11, 1'b0);
    single("br_min",   32'hFFFE_0000, 1'b1, 16'h8000, 2'b11, 1'b0);
    single("br_unal",  32'h0000_0006, 1'b1, 16'h0000, 2'b11, 1'b1);
    single("br_range", 32'h0002_0000, 1'b1, 16'h0000, 2'b11, 1'b1);

    pair("split",      32'h1234_5678, 16'h1234, 16'h5678, 3);
    pair("split_b15",  32'h0001_8000, 16'h0001, 16'h8000, 0);
    pair("split_hi",   32'h8000_FFFF, 16'h8000, 16'hFFFF, 0);

    // Back-to-back: second request accepted on the last-beat handshake.
    in_valid = 1'b1; in_val = 32'h0000_0007; in_br = 1'b0;
    @(posedge clk); #1;
    in_val = 32'h1234_0000;
    chk_beat("b2b.a", 16'h0007, 2'b00, 1'b1, 1'b0);
    check_eq("b2b.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_beat("b2b.b", 16'h1234, 2'b10, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_idle("b2b");

    // Reset asserted while the ori beat is pending.
    in_valid = 1'b1; in_val = 32'h1234_5678; in_br = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_beat("rstmid.b2", 16'h5678, 2'b01, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rstmid.valid",    {31'd0, out_valid}, 32'd0);
    check_eq("rstmid.in_ready", {31'd0, in_ready},  32'd0);
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("rstmid.ready_after", {31'd0, in_ready},  32'd1);
    check_eq("rstmid.valid_after", {31'd0, out_valid}, 32'd0);
    single("rstmid.clean", 32'h0000_0005, 1'b0, 16'h0005, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
